// File: rtl/bus_addr_seq_pkg.sv
// ============================================================================
// Module : bus_addr_seq_pkg
// Desc   : Shared register map, FSM encoding and base-register byte helper
//          for the bus address sequencer.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package bus_addr_seq_pkg;

    localparam logic [6:0] REG_BASE_LO  = 7'h7C;
    localparam logic [6:0] REG_BASE_MID = 7'h7D;
    localparam logic [6:0] REG_BASE_HI  = 7'h7E;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACTIVE = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    // Selector is address_bus[1:0]: 7C->0, 7D->1, 7E->2.
    function automatic logic [7:0] reg_byte(input logic [16:0] base, input logic [1:0] sel);
        logic [7:0] b;
        b = 8'h00;
        case (sel)
            2'd0:    b = base[7:0];
            2'd1:    b = base[15:8];
            2'd2:    b = {7'b0, base[16]};
            default: b = 8'h00;
        endcase
        return b;
    endfunction

endpackage

`default_nettype wire

// File: rtl/bus_addr_seq_sync_ff.sv
// ============================================================================
// Module : sync_ff
// Desc   : SYNC-deep synchronizer for one asynchronous active-low strobe;
//          flops preset to 1 (inactive) on reset.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module sync_ff #(
    parameter int SYNC = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [SYNC-1:0] chain;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            chain <= '1;
        end else begin
            chain <= {chain[SYNC-2:0], d};
        end
    end

    assign q = chain[SYNC-1];

endmodule

`default_nettype wire

// File: rtl/bus_addr_seq.sv
// ============================================================================
// Module : bus_addr_seq
// Desc   : Bus-to-SRAM address sequencer: synchronizes bus strobes, issues
//          single-cycle rd/wr requests and builds mem_address = base + addr.
//          Optional build macro AUTOINC_EN: base increments after each data cycle.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module bus_addr_seq
    import bus_addr_seq_pkg::*;
#(
    parameter int AW   = 17,
    parameter int BW   = 7,
    parameter int DW   = 8,
    parameter int SYNC = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          ce_n,
    input  logic          read_n,
    input  logic          write_n,
    input  logic [BW-1:0] address_bus,
    input  logic [DW-1:0] data_in,
    output logic [AW-1:0] mem_address,
    output logic          rd_strobe,
    output logic          wr_strobe,
    output logic [DW-1:0] wr_data,
    output logic [DW-1:0] reg_rdata,
    output logic          busy,
    output logic          bus_err
);

    logic ce_s, rd_s, wr_s;

    sync_ff #(.SYNC(SYNC)) u_sync_ce (.clk(clk), .reset(reset), .d(ce_n),    .q(ce_s));
    sync_ff #(.SYNC(SYNC)) u_sync_rd (.clk(clk), .reset(reset), .d(read_n),  .q(rd_s));
    sync_ff #(.SYNC(SYNC)) u_sync_wr (.clk(clk), .reset(reset), .d(write_n), .q(wr_s));

    state_t     state, next_state;
    logic       start, bad_cycle, addr_is_reg;
    logic       txn_reg, txn_wr, txn_err;
    logic [1:0] txn_sel;

    assign start       = !ce_s && (rd_s ^ wr_s);
    assign bad_cycle   = !ce_s && !rd_s && !wr_s;
    assign addr_is_reg = (address_bus == BW'(REG_BASE_LO))  ||
                         (address_bus == BW'(REG_BASE_MID)) ||
                         (address_bus == BW'(REG_BASE_HI));
    assign busy        = (state != S_IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // A cycle ends only on ce release; strobe release alone keeps us ACTIVE.
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:   if (start || bad_cycle) next_state = S_ACTIVE;
            S_ACTIVE: if (ce_s)               next_state = S_DONE;
            S_DONE:   next_state = S_IDLE;
            default:  next_state = S_IDLE;
        endcase
    end

    logic [AW-1:0] base;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            base        <= '0;
            mem_address <= '0;
            rd_strobe   <= 1'b0;
            wr_strobe   <= 1'b0;
            wr_data     <= '0;
            reg_rdata   <= '0;
            bus_err     <= 1'b0;
            txn_reg     <= 1'b0;
            txn_wr      <= 1'b0;
            txn_err     <= 1'b0;
            txn_sel     <= '0;
        end else begin
            rd_strobe <= 1'b0;
            wr_strobe <= 1'b0;
            if (state == S_IDLE && start) begin
                mem_address <= base + {{(AW-BW){1'b0}}, address_bus};
                txn_reg     <= addr_is_reg;
                txn_wr      <= !wr_s;
                txn_err     <= 1'b0;
                txn_sel     <= address_bus[1:0];
                if (!wr_s) begin
                    wr_data <= data_in;
                end
                if (!addr_is_reg) begin
                    rd_strobe <= !rd_s;
                    wr_strobe <= !wr_s;
                end else if (!rd_s) begin
                    reg_rdata <= reg_byte(base, address_bus[1:0]);
                end
            end else if (state == S_IDLE && bad_cycle) begin
                bus_err <= 1'b1;
                txn_err <= 1'b1;
                txn_reg <= 1'b0;
                txn_wr  <= 1'b0;
            end else if (state == S_DONE) begin
                reg_rdata <= '0;
                // Register write wins over auto-increment in the same DONE.
                if (txn_reg && txn_wr) begin
                    case (txn_sel)
                        2'd0:    base[7:0]  <= wr_data;
                        2'd1:    base[15:8] <= wr_data;
                        2'd2:    base[16]   <= wr_data[0];
                        default: base       <= base;
                    endcase
                end
`ifdef AUTOINC_EN
                else if (!txn_reg && !txn_err) begin
                    base <= base + AW'(1);
                end
`endif
            end
        end
    end

endmodule

`default_nettype wire
